// File: rtl/fifo_rd_stream_if.sv
// Downstream valid/ready word stream leaving the read-domain consumer.
// The master drives valid and data, and the slave answers with ready.
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        output m_valid,
        output m_data,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        output m_ready
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-domain consumer of the async FIFO: issues rinc and feeds a 2-entry skid buffer
// so the downstream stream runs at one word per cycle. Also reports fill level and almost-empty.
module fifo_rd_stream #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDRESS_BITS = 4,
    parameter int AE_THRESH    = 2
) (
    input  logic                    rclk,
    input  logic                    rrst,
    input  logic                    rempty,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [ADDRESS_BITS:0]   rptr,
    input  logic [ADDRESS_BITS:0]   rq2_write_ptr,
    input  logic                    flush,
    output logic                    rinc,
    output logic [ADDRESS_BITS:0]   rlevel,
    output logic                    ralmost_empty,
    output logic [15:0]             rd_count,
    fifo_rd_stream_if.master        stream
);
    localparam int PW = ADDRESS_BITS + 1;
    localparam logic [PW-1:0] AE_LIMIT = PW'(AE_THRESH);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

    state_t                state_reg, state_next;
    logic [DATA_WIDTH-1:0] head_reg, head_next;
    logic [DATA_WIDTH-1:0] skid_reg, skid_next;
    logic [15:0]           rd_count_reg;
    logic [PW-1:0]         rlevel_reg;
    logic                  ralmost_empty_reg;
    logic                  valid_int;
    logic                  pop;
    logic                  rinc_int;
    logic [PW-1:0]         wbin;
    logic [PW-1:0]         rbin;
    logic [PW-1:0]         diff;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_gray2bin
            assign wbin[gi] = ^rq2_write_ptr[PW-1:gi];
            assign rbin[gi] = ^rptr[PW-1:gi];
        end
    endgenerate

    // Modulo subtraction absorbs the lap bit, so pointer wrap needs no special case.
    assign diff = wbin - rbin;

    always_comb begin
        valid_int  = (state_reg != S_EMPTY) && !flush;
        pop        = valid_int && stream.m_ready;
        // A word is only read when a slot will be free at the coming edge.
        rinc_int   = rrst && !rempty && !flush && ((state_reg != S_TWO) || pop);
        state_next = state_reg;
        head_next  = head_reg;
        skid_next  = skid_reg;
        case (state_reg)
            S_EMPTY: begin
                if (rinc_int) begin
                    head_next  = rdata;
                    state_next = S_ONE;
                end
            end
            S_ONE: begin
                case ({rinc_int, pop})
                    2'b10: begin
                        skid_next  = rdata;
                        state_next = S_TWO;
                    end
                    2'b11: head_next  = rdata;
                    2'b01: state_next = S_EMPTY;
                    default: ;
                endcase
            end
            S_TWO: begin
                if (pop) begin
                    head_next = skid_reg;
                    if (rinc_int) begin
                        skid_next = rdata;
                    end else begin
                        state_next = S_ONE;
                    end
                end
            end
            default: state_next = S_EMPTY;
        endcase
        if (flush) begin
            state_next = S_EMPTY;
        end
    end

    always_ff @(posedge rclk or negedge rrst) begin
        if (!rrst) begin
            state_reg         <= S_EMPTY;
            head_reg          <= '0;
            skid_reg          <= '0;
            rd_count_reg      <= '0;
            rlevel_reg        <= '0;
            ralmost_empty_reg <= 1'b1;
        end else begin
            state_reg         <= state_next;
            head_reg          <= head_next;
            skid_reg          <= skid_next;
            rlevel_reg        <= diff;
            ralmost_empty_reg <= (diff <= AE_LIMIT);
            if (pop) begin
                rd_count_reg <= rd_count_reg + 16'd1;
            end
        end
    end

    assign rinc           = rinc_int;
    assign stream.m_valid = valid_int;
    assign stream.m_data  = head_reg;
    assign rd_count       = rd_count_reg;
    assign rlevel         = rlevel_reg;
    assign ralmost_empty  = ralmost_empty_reg;
endmodule
